// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature encoder front end: Gray states,
// default position limits and the transition classifier.
package quad_pkg;

  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  localparam int unsigned POS_INIT_DEF = 32'd500;
  localparam int unsigned POS_MAX_DEF  = 32'd999;

  typedef enum logic [1:0] {
    DEC_NONE    = 2'b00,
    DEC_FWD     = 2'b01,
    DEC_REV     = 2'b10,
    DEC_ILLEGAL = 2'b11
  } dec_e;

  // Classifies an {A,B} old->new pair; both bits flipping is not a valid step.
  function automatic dec_e quad_decode(input logic [1:0] old_ab, input logic [1:0] new_ab);
    dec_e res;
    case ({old_ab, new_ab})
      {S00, S01}, {S01, S11}, {S11, S10}, {S10, S00}: res = DEC_FWD;
      {S01, S00}, {S11, S01}, {S10, S11}, {S00, S10}: res = DEC_REV;
      default: begin
        if ((old_ab ^ new_ab) == 2'b11) begin
          res = DEC_ILLEGAL;
        end else begin
          res = DEC_NONE;
        end
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/quad_encoder_frontend_if.sv
// Encoder pins in, position/velocity results out; the frontend is the slave,
// the encoder source (board pins or a bench) is the master.
interface quad_encoder_frontend_if #(
  parameter int unsigned POS_WIDTH = 13,
  parameter int unsigned VEL_WIDTH = 12
);
  logic                        i_A;
  logic                        i_B;
  logic [POS_WIDTH-1:0]        o_Position;
  logic                        o_Direction;
  logic                        o_Step;
  logic signed [VEL_WIDTH-1:0] o_Velocity;
  logic                        o_VelDV;
  logic                        o_Error;

  modport master (
    output i_A, i_B,
    input  o_Position, o_Direction, o_Step, o_Velocity, o_VelDV, o_Error
  );

  modport slave (
    input  i_A, i_B,
    output o_Position, o_Direction, o_Step, o_Velocity, o_VelDV, o_Error
  );
endinterface

// File: rtl/quad_input_filter.sv
// Two-flop synchroniser followed by a stability filter: a new level is accepted
// only after it has differed from the filtered level for FILTER_LEN cycles.
module quad_input_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic raw_i,
  output logic filt_o
);

  localparam int unsigned CNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser, filtered level and stability counter.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= CNT_W'(0);
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
        cnt_d  = CNT_W'(0);
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = CNT_W'(0);
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/quad_encoder_frontend.sv
// Quadrature front end: filtered A/B, 4x decode into a clamped position count,
// sticky illegal-transition flag and a signed steps-per-window velocity sample.
module quad_encoder_frontend
  import quad_pkg::*;
#(
  parameter int unsigned POS_WIDTH  = 13,
  parameter int unsigned POS_INIT   = POS_INIT_DEF,
  parameter int unsigned POS_MAX    = POS_MAX_DEF,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned VEL_WINDOW = 65536,
  parameter int unsigned VEL_WIDTH  = 12
) (
  input  logic                   Clk,
  input  logic                   Rst,
  quad_encoder_frontend_if.slave enc
);

  localparam int unsigned WIN_W = (VEL_WINDOW > 1) ? $clog2(VEL_WINDOW) : 1;
  localparam logic [WIN_W-1:0]         WIN_LAST    = WIN_W'(VEL_WINDOW - 1);
  localparam logic [POS_WIDTH-1:0]     POS_MAX_V   = POS_WIDTH'(POS_MAX);
  localparam logic [POS_WIDTH-1:0]     POS_INIT_V  = POS_WIDTH'(POS_INIT);
  localparam logic signed [VEL_WIDTH:0] VEL_POS_LIM = (VEL_WIDTH + 1)'((2 ** (VEL_WIDTH - 1)) - 1);
  localparam logic signed [VEL_WIDTH:0] VEL_NEG_LIM = -VEL_POS_LIM;

  logic                        filt_a_s, filt_b_s;
  logic [1:0]                  filt_ab_s;
  dec_e                        dec_s;
  logic                        fwd_s, rev_s;
  logic signed [VEL_WIDTH:0]   delta_s, acc_sum_s;
  logic signed [VEL_WIDTH-1:0] acc_sat_s;

  logic [1:0]                  ab_q, ab_d;
  logic                        primed_q, primed_d;
  logic [POS_WIDTH-1:0]        pos_q, pos_d;
  logic                        dir_q, dir_d;
  logic                        step_q, step_d;
  logic                        err_q, err_d;
  logic [WIN_W-1:0]            win_q, win_d;
  logic signed [VEL_WIDTH-1:0] acc_q, acc_d;
  logic signed [VEL_WIDTH-1:0] vel_q, vel_d;
  logic                        vdv_q, vdv_d;

  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .Clk(Clk), .Rst(Rst), .raw_i(enc.i_A), .filt_o(filt_a_s)
  );
  quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .Clk(Clk), .Rst(Rst), .raw_i(enc.i_B), .filt_o(filt_b_s)
  );

  assign filt_ab_s = {filt_a_s, filt_b_s};

  // Decode state, position, direction, step and error registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ab_q     <= S00;
      primed_q <= 1'b0;
      pos_q    <= POS_INIT_V;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      win_q    <= WIN_W'(0);
      acc_q    <= VEL_WIDTH'(0);
      vel_q    <= VEL_WIDTH'(0);
      vdv_q    <= 1'b0;
    end else begin
      ab_q     <= ab_d;
      primed_q <= primed_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      err_q    <= err_d;
      win_q    <= win_d;
      acc_q    <= acc_d;
      vel_q    <= vel_d;
      vdv_q    <= vdv_d;
    end
  end

  // The first filtered change after reset only captures the resting state.
  always_comb begin
    ab_d     = ab_q;
    primed_d = primed_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    err_d    = err_q;
    fwd_s    = 1'b0;
    rev_s    = 1'b0;
    dec_s    = quad_decode(ab_q, filt_ab_s);
    if (filt_ab_s != ab_q) begin
      ab_d = filt_ab_s;
      if (!primed_q) begin
        primed_d = 1'b1;
      end else begin
        case (dec_s)
          DEC_FWD: begin
            fwd_s  = 1'b1;
            step_d = 1'b1;
            dir_d  = 1'b1;
            if (pos_q < POS_MAX_V) begin
              pos_d = pos_q + POS_WIDTH'(1);
            end else begin
              pos_d = pos_q;
            end
          end
          DEC_REV: begin
            rev_s  = 1'b1;
            step_d = 1'b1;
            dir_d  = 1'b0;
            if (pos_q != POS_WIDTH'(0)) begin
              pos_d = pos_q - POS_WIDTH'(1);
            end else begin
              pos_d = pos_q;
            end
          end
          DEC_ILLEGAL: err_d = 1'b1;
          default:     err_d = err_q;
        endcase
      end
    end else begin
      ab_d = ab_q;
    end
  end

  // Velocity window: the terminal cycle's own step lands in the closing sample.
  always_comb begin
    if (fwd_s) begin
      delta_s = (VEL_WIDTH + 1)'(1);
    end else if (rev_s) begin
      delta_s = -((VEL_WIDTH + 1)'(1));
    end else begin
      delta_s = (VEL_WIDTH + 1)'(0);
    end
    acc_sum_s = $signed({acc_q[VEL_WIDTH-1], acc_q}) + delta_s;
    if (acc_sum_s > VEL_POS_LIM) begin
      acc_sat_s = VEL_POS_LIM[VEL_WIDTH-1:0];
    end else if (acc_sum_s < VEL_NEG_LIM) begin
      acc_sat_s = VEL_NEG_LIM[VEL_WIDTH-1:0];
    end else begin
      acc_sat_s = acc_sum_s[VEL_WIDTH-1:0];
    end
    if (win_q == WIN_LAST) begin
      win_d = WIN_W'(0);
      vel_d = acc_sat_s;
      vdv_d = 1'b1;
      acc_d = VEL_WIDTH'(0);
    end else begin
      win_d = win_q + WIN_W'(1);
      vel_d = vel_q;
      vdv_d = 1'b0;
      acc_d = acc_sat_s;
    end
  end

  assign enc.o_Position  = pos_q;
  assign enc.o_Direction = dir_q;
  assign enc.o_Step      = step_q;
  assign enc.o_Velocity  = vel_q;
  assign enc.o_VelDV     = vdv_q;
  assign enc.o_Error     = err_q;

endmodule
